// File: rtl/regincr_rr_sched.sv
// Round-robin two-requester front end for a shared register + incrementer datapath.
// Optional saturating increment: define REGINCR_RR_SCHED_SAT_EN.
module regincr_rr_sched #(
    parameter int nbits  = 8,
    parameter int npbits = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_val,
    output logic              req0_rdy,
    input  logic [nbits-1:0]  req0_data,
    input  logic [npbits-1:0] req0_npass,
    input  logic              req1_val,
    output logic              req1_rdy,
    input  logic [nbits-1:0]  req1_data,
    input  logic [npbits-1:0] req1_npass,
    output logic              resp_val,
    input  logic              resp_rdy,
    output logic [nbits-1:0]  resp_data,
    output logic              resp_id
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [nbits-1:0] ONE_D  = 1;
    localparam logic [npbits:0]  ONE_P  = 1;

    logic [1:0]        state_q, state_d;
    logic [nbits-1:0]  tmp_q,   tmp_d;
    logic [npbits:0]   rem_q,   rem_d;
    logic              owner_q, owner_d;
    logic              prio_q,  prio_d;

    logic grant0, grant1;

    function automatic logic [nbits-1:0] incr(input logic [nbits-1:0] v);
`ifdef REGINCR_RR_SCHED_SAT_EN
        return (&v) ? v : v + ONE_D;
`else
        return v + ONE_D;
`endif
    endfunction

    // A lone requester always wins; on contention the pointer decides.
    always_comb begin
        grant0 = req0_val && (!req1_val || !prio_q);
        grant1 = req1_val && (!req0_val ||  prio_q);
    end

    assign req0_rdy  = (state_q == IDLE) && grant0;
    assign req1_rdy  = (state_q == IDLE) && grant1;
    assign resp_val  = (state_q == DONE);
    assign resp_data = resp_val ? tmp_q : '0;
    assign resp_id   = resp_val & owner_q;

    always_comb begin
        state_d = state_q;
        tmp_d   = tmp_q;
        rem_d   = rem_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (grant0) begin
                    tmp_d   = req0_data;
                    rem_d   = {1'b0, req0_npass} + ONE_P;
                    owner_d = 1'b0;
                    prio_d  = 1'b1;
                    state_d = BUSY;
                end else if (grant1) begin
                    tmp_d   = req1_data;
                    rem_d   = {1'b0, req1_npass} + ONE_P;
                    owner_d = 1'b1;
                    prio_d  = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                tmp_d = incr(tmp_q);
                rem_d = rem_q - ONE_P;
                if (rem_q == ONE_P) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // Returning to IDLE here means the next grant lands a cycle later.
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmp_q   <= '0;
            rem_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmp_q   <= tmp_d;
            rem_q   <= rem_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

endmodule

// File: tb/tb_regincr_rr_sched.sv
// Bench for regincr_rr_sched: transaction-level reference model plus directed literal checks.
// Honours REGINCR_RR_SCHED_SAT_EN for the expected increment result.
module tb_regincr_rr_sched;

    logic       clk;
    logic       reset;
    logic       req0_val, req0_rdy;
    logic [7:0] req0_data;
    logic [1:0] req0_npass;
    logic       req1_val, req1_rdy;
    logic [7:0] req1_data;
    logic [1:0] req1_npass;
    logic       resp_val, resp_rdy;
    logic [7:0] resp_data;
    logic       resp_id;

    int n_checks = 0;
    int n_pass   = 0;

    regincr_rr_sched #(.nbits(8), .npbits(2)) dut (
        .clk(clk), .reset(reset),
        .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_data(req0_data), .req0_npass(req0_npass),
        .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_data(req1_data), .req1_npass(req1_npass),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data), .resp_id(resp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Result of a request: data plus number of increments, wrapped or clamped.
    function automatic logic [7:0] model_result(input logic [7:0] d, input int n);
        int s;
        s = int'(d) + n;
`ifdef REGINCR_RR_SCHED_SAT_EN
        return (s > 255) ? 8'hFF : 8'(s);
`else
        return 8'(s % 256);
`endif
    endfunction

    // Reference model: a request occupies the datapath for k+1 cycles, then waits for the consumer.
    logic       m_on = 1'b0;
    logic       m_idle, m_done, m_id, m_prio;
    int         m_left;
    logic [7:0] m_res;
    logic       eg0, eg1;

    assign eg0 = m_idle && req0_val && (!req1_val || !m_prio);
    assign eg1 = m_idle && req1_val && (!req0_val ||  m_prio);

    always @(posedge clk) begin
        if (reset) begin
            m_on   <= 1'b1;
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_left <= 0;
            m_prio <= 1'b0;
            m_id   <= 1'b0;
            m_res  <= 8'h00;
        end else if (m_idle) begin
            if (eg0 || eg1) begin
                m_idle <= 1'b0;
                m_id   <= eg1;
                m_prio <= !eg1;
                m_left <= eg1 ? int'(req1_npass) + 1 : int'(req0_npass) + 1;
                m_res  <= eg1 ? model_result(req1_data, int'(req1_npass) + 1)
                              : model_result(req0_data, int'(req0_npass) + 1);
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1'b1;
        end else if (m_done && resp_rdy) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("mdl_rdy0", req0_rdy, eg0);
            chk("mdl_rdy1", req1_rdy, eg1);
            chk("mdl_val", resp_val, m_done);
            if (m_done) begin
                chk("mdl_data", resp_data, m_res);
                chk("mdl_id", resp_id, m_id);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic       glog[$];
    logic [7:0] dlog[$];
    logic       ilog[$];

    initial begin
        reset = 1'b1; resp_rdy = 1'b1;
        req0_val = 0; req0_data = 0; req0_npass = 0;
        req1_val = 0; req1_data = 0; req1_npass = 0;
        nxt(); nxt();
        smp();
        chk("rst_val", resp_val, 0);
        chk("rst_rdy0", req0_rdy, 0);
        chk("rst_rdy1", req1_rdy, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_id", resp_id, 0);
        nxt();
        reset = 1'b0;
        nxt();

        // Single request, one pass
        req0_val = 1; req0_data = 8'h05; req0_npass = 0;
        smp(); chk("t1_rdy0", req0_rdy, 1); chk("t1_rdy1", req1_rdy, 0);
        nxt(); req0_val = 0;
        smp(); chk("t1_busy", resp_val, 0);
        nxt();
        smp(); chk("t1_val", resp_val, 1); chk("t1_data", resp_data, 8'h06); chk("t1_id", resp_id, 0);
        nxt();

        // Multi-pass from requester 1
        req1_val = 1; req1_data = 8'h10; req1_npass = 3;
        smp(); chk("t2_rdy1", req1_rdy, 1);
        nxt(); req1_val = 0;
        for (int i = 0; i < 4; i++) begin
            smp(); chk("t2_wait", resp_val, 0);
            nxt();
        end
        smp(); chk("t2_val", resp_val, 1); chk("t2_data", resp_data, 8'h14); chk("t2_id", resp_id, 1);
        nxt();

        // Contention
        req0_val = 1; req0_data = 8'hA0; req0_npass = 0;
        req1_val = 1; req1_data = 8'hB0; req1_npass = 0;
        for (int c = 0; c < 14; c++) begin
            smp();
            if (req0_rdy) glog.push_back(1'b0);
            if (req1_rdy) glog.push_back(1'b1);
            if (resp_val && resp_rdy) begin
                dlog.push_back(resp_data);
                ilog.push_back(resp_id);
            end
            nxt();
            if (glog.size() >= 4) begin
                req0_val = 0; req1_val = 0;
            end
        end
        chk("t3_ngrant", glog.size(), 4);
        chk("t3_nresp", dlog.size(), 4);
        if (glog.size() >= 4 && dlog.size() >= 4) begin
            chk("t3_g0", glog[0], 0); chk("t3_g1", glog[1], 1);
            chk("t3_g2", glog[2], 0); chk("t3_g3", glog[3], 1);
            chk("t3_d0", dlog[0], 8'hA1); chk("t3_d1", dlog[1], 8'hB1);
            chk("t3_d2", dlog[2], 8'hA1); chk("t3_d3", dlog[3], 8'hB1);
            chk("t3_i0", ilog[0], 0); chk("t3_i1", ilog[1], 1);
        end

        // Backpressure in DONE
        resp_rdy = 0;
        req0_val = 1; req0_data = 8'h30; req0_npass = 1;
        smp(); chk("t4_rdy0", req0_rdy, 1);
        nxt(); req0_val = 0;
        smp(); nxt(); smp(); nxt();
        req0_val = 1; req1_val = 1; req1_data = 8'h40; req1_npass = 0;
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("t4_val", resp_val, 1); chk("t4_data", resp_data, 8'h32); chk("t4_id", resp_id, 0);
            chk("t4_rdy0", req0_rdy, 0); chk("t4_rdy1", req1_rdy, 0);
            nxt();
        end
        resp_rdy = 1;
        smp(); chk("t4_rel", resp_val, 1);
        nxt();
        smp(); chk("t4_idle_val", resp_val, 0); chk("t4_idle_g1", req1_rdy, 1);
        nxt(); req0_val = 0; req1_val = 0;
        repeat (4) nxt();

        // Wrap / saturate
        req0_val = 1; req0_data = 8'hFE; req0_npass = 2;
        smp(); chk("t5_rdy0", req0_rdy, 1);
        nxt(); req0_val = 0;
        for (int i = 0; i < 3; i++) begin
            smp(); chk("t5_wait", resp_val, 0);
            nxt();
        end
        smp(); chk("t5_val", resp_val, 1);
`ifdef REGINCR_RR_SCHED_SAT_EN
        chk("t5_data", resp_data, 8'hFF);
`else
        chk("t5_data", resp_data, 8'h01);
`endif
        nxt();

        // Reset while BUSY drops the request and clears the pointer
        req1_val = 1; req1_data = 8'h20; req1_npass = 3;
        smp(); chk("t6_rdy1", req1_rdy, 1);
        nxt(); req1_val = 0;
        smp(); nxt();
        reset = 1;
        smp(); nxt();
        reset = 0;
        req0_val = 1; req0_data = 8'h50; req0_npass = 0;
        req1_val = 1; req1_data = 8'h60; req1_npass = 0;
        smp(); chk("t6_rdy0", req0_rdy, 1); chk("t6_rdy1", req1_rdy, 0); chk("t6_val", resp_val, 0);
        nxt(); req0_val = 0; req1_val = 0;
        smp(); chk("t6_busy", resp_val, 0);
        nxt();
        smp(); chk("t6_rval", resp_val, 1); chk("t6_data", resp_data, 8'h51); chk("t6_id", resp_id, 0);
        repeat (4) nxt();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
